// File: rtl/heap_alloc_pkg.sv
// rtl/heap_alloc_pkg.sv - shared widths, types and error causes for the heap array allocator
package heap_alloc_pkg;
   localparam int MEM_W    = 12;
   localparam int N_ARRAYS = 4;
   localparam int N_AREA   = 8;
   localparam int SP_W     = $clog2(N_ARRAYS + 1);

   typedef logic [MEM_W-1:0] handle_t;
   typedef logic [MEM_W-1:0] size_t;

   typedef enum logic [1:0] {
      ERR_NONE,
      ERR_NO_HANDLE,
      ERR_NOT_IN_USE,
      ERR_INDEX_RANGE
   } err_cause_e;
endpackage

// File: rtl/freed_array_stack.sv
// rtl/freed_array_stack.sv - LIFO of released handles with push, pop and same-cycle replace
module freed_array_stack
   import heap_alloc_pkg::*;
#(
   parameter int W      = MEM_W,
   parameter int DEPTH  = N_ARRAYS,
   parameter int SP_W_P = SP_W
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              i_push,
   input  logic              i_pop,
   input  logic [W-1:0]      i_push_data,
   output logic [W-1:0]      o_top_data,
   output logic [SP_W_P-1:0] o_top,
   output logic              o_empty
);
   localparam int LP_IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [W-1:0]        r_mem [DEPTH];
   logic [SP_W_P-1:0]   r_top;
   logic [SP_W_P-1:0]   w_top_m1;
   logic [LP_IDX_W-1:0] w_rd_idx;
   logic [LP_IDX_W-1:0] w_wr_idx;
   logic                w_pop_ok;

   assign w_top_m1   = r_top - SP_W_P'(1);
   assign w_rd_idx   = w_top_m1[LP_IDX_W-1:0];
   assign w_wr_idx   = r_top[LP_IDX_W-1:0];
   assign w_pop_ok   = i_pop && (r_top != '0);
   assign o_top_data = r_mem[w_rd_idx];
   assign o_top      = r_top;
   assign o_empty    = (r_top == '0);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_top <= '0;
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else begin
         case ({i_push, w_pop_ok})
            // pop then push lands in the slot just vacated, so depth is unchanged
            2'b11: r_mem[w_rd_idx] <= i_push_data;
            2'b10: begin
               r_mem[w_wr_idx] <= i_push_data;
               r_top           <= r_top + SP_W_P'(1);
            end
            2'b01: r_top <= w_top_m1;
            default: ;
         endcase
      end
   end
endmodule

// File: rtl/heap_array_allocator.sv
// rtl/heap_array_allocator.sv - array handle allocation, release and size tracking
module heap_array_allocator
   import heap_alloc_pkg::*;
#(
   parameter int MemoryElementWidth = MEM_W,
   parameter int NArrays            = N_ARRAYS,
   parameter int NArea              = N_AREA
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          alloc_req,
   output logic                          alloc_ack,
   output logic [MemoryElementWidth-1:0] alloc_array,
   output logic                          alloc_error,
   input  logic                          free_req,
   input  logic [MemoryElementWidth-1:0] free_array,
   output logic                          free_error,
   input  logic                          upd_valid,
   input  logic [MemoryElementWidth-1:0] upd_array,
   input  logic [MemoryElementWidth-1:0] upd_index,
   output logic                          upd_error,
   input  logic [MemoryElementWidth-1:0] qry_array,
   output logic [MemoryElementWidth-1:0] qry_size,
   output logic [MemoryElementWidth-1:0] alloc_count,
   output logic [MemoryElementWidth-1:0] in_use_count
);
   localparam int LP_SP_W  = $clog2(NArrays + 1);
   localparam int LP_IDX_W = (NArrays > 1) ? $clog2(NArrays) : 1;
   localparam logic [MemoryElementWidth-1:0] LP_N_ARR  = MemoryElementWidth'(NArrays);
   localparam logic [MemoryElementWidth-1:0] LP_N_AREA = MemoryElementWidth'(NArea);

   logic [NArrays-1:0]            r_in_use;
   logic [MemoryElementWidth-1:0] r_size [NArrays];
   logic [MemoryElementWidth-1:0] r_allocs;
   logic [MemoryElementWidth-1:0] r_in_use_cnt;

   logic [MemoryElementWidth-1:0] w_stack_data;
   logic [LP_SP_W-1:0]            w_stack_top;
   logic                          w_empty;
   logic                          w_pop, w_mint, w_grant, w_free_ok, w_upd_ok;
   logic [MemoryElementWidth-1:0] w_grant_h;
   logic [MemoryElementWidth-1:0] w_upd_len;
   logic [LP_IDX_W-1:0]           w_grant_idx, w_free_idx, w_upd_idx, w_qry_idx;

   assign w_grant_idx = w_grant_h[LP_IDX_W-1:0];
   assign w_free_idx  = free_array[LP_IDX_W-1:0];
   assign w_upd_idx   = upd_array[LP_IDX_W-1:0];
   assign w_qry_idx   = qry_array[LP_IDX_W-1:0];

   // recycled handles take priority over minting fresh ones
   assign w_pop     = alloc_req && !w_empty;
   assign w_mint    = alloc_req && w_empty && (r_allocs < LP_N_ARR);
   assign w_grant   = w_pop || w_mint;
   assign w_grant_h = w_pop ? w_stack_data : r_allocs;
   assign w_free_ok = free_req && (free_array < LP_N_ARR) && r_in_use[w_free_idx];
   assign w_upd_ok  = upd_valid && (upd_array < LP_N_ARR) && r_in_use[w_upd_idx]
                      && (upd_index < LP_N_AREA);
   assign w_upd_len = upd_index + MemoryElementWidth'(1);

   assign alloc_count  = r_allocs;
   assign in_use_count = r_in_use_cnt;

   freed_array_stack #(
      .W      (MemoryElementWidth),
      .DEPTH  (NArrays),
      .SP_W_P (LP_SP_W)
   ) u_stack (
      .clock       (clock),
      .reset       (reset),
      .i_push      (w_free_ok),
      .i_pop       (w_pop),
      .i_push_data (free_array),
      .o_top_data  (w_stack_data),
      .o_top       (w_stack_top),
      .o_empty     (w_empty)
   );

   always_comb begin
      if (reset) assert (w_stack_top <= LP_SP_W'(NArrays));
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         alloc_ack    <= 1'b0;
         alloc_array  <= '0;
         alloc_error  <= 1'b0;
         free_error   <= 1'b0;
         upd_error    <= 1'b0;
         qry_size     <= '0;
         r_allocs     <= '0;
         r_in_use     <= '0;
         r_in_use_cnt <= '0;
         for (int i = 0; i < NArrays; i++) r_size[i] <= '0;
      end else begin
         alloc_ack   <= w_grant;
         alloc_array <= w_grant ? w_grant_h : '0;
         alloc_error <= alloc_req && !w_grant;
         free_error  <= free_req && !w_free_ok;
         upd_error   <= upd_valid && !w_upd_ok;
         qry_size    <= (qry_array < LP_N_ARR) ? r_size[w_qry_idx] : '0;
         if (w_mint) r_allocs <= r_allocs + MemoryElementWidth'(1);
         if (w_upd_ok && (w_upd_len > r_size[w_upd_idx])) r_size[w_upd_idx] <= w_upd_len;
         // granted and freed handles always differ: one is in use pre-edge, the other is not
         if (w_grant) begin
            r_size[w_grant_idx]   <= '0;
            r_in_use[w_grant_idx] <= 1'b1;
         end
         if (w_free_ok) r_in_use[w_free_idx] <= 1'b0;
         case ({w_grant, w_free_ok})
            2'b10:   r_in_use_cnt <= r_in_use_cnt + MemoryElementWidth'(1);
            2'b01:   r_in_use_cnt <= r_in_use_cnt - MemoryElementWidth'(1);
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_heap_array_allocator.sv
// tb/tb_heap_array_allocator.sv - randomized and directed bench against a queue-based model
module tb_heap_array_allocator;
   import heap_alloc_pkg::*;

   localparam int NA    = N_ARRAYS;
   localparam int NAREA = N_AREA;

   logic    clock = 1'b0;
   logic    reset = 1'b0;
   logic    alloc_req = 1'b0, free_req = 1'b0, upd_valid = 1'b0;
   handle_t free_array = '0, upd_array = '0, upd_index = '0, qry_array = '0;
   logic    alloc_ack, alloc_error, free_error, upd_error;
   handle_t alloc_array;
   size_t   qry_size, alloc_count, in_use_count;

   always #5 clock = ~clock;

   heap_array_allocator dut (
      .clock        (clock),
      .reset        (reset),
      .alloc_req    (alloc_req),
      .alloc_ack    (alloc_ack),
      .alloc_array  (alloc_array),
      .alloc_error  (alloc_error),
      .free_req     (free_req),
      .free_array   (free_array),
      .free_error   (free_error),
      .upd_valid    (upd_valid),
      .upd_array    (upd_array),
      .upd_index    (upd_index),
      .upd_error    (upd_error),
      .qry_array    (qry_array),
      .qry_size     (qry_size),
      .alloc_count  (alloc_count),
      .in_use_count (in_use_count)
   );

   int checks = 0;
   int errors = 0;

   int         fq[$];
   int         m_allocs;
   bit         m_inuse [NA];
   int         m_size  [NA];
   err_cause_e e_cause;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got %0d want %0d", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      fq.delete();
      m_allocs = 0;
      for (int i = 0; i < NA; i++) begin
         m_inuse[i] = 1'b0;
         m_size[i]  = 0;
      end
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_ack"},    32'(alloc_ack), 0);
      chk({tag, "_arr"},    32'(alloc_array), 0);
      chk({tag, "_aerr"},   32'(alloc_error), 0);
      chk({tag, "_ferr"},   32'(free_error), 0);
      chk({tag, "_uerr"},   32'(upd_error), 0);
      chk({tag, "_qry"},    32'(qry_size), 0);
      chk({tag, "_acnt"},   32'(alloc_count), 0);
      chk({tag, "_inuse"},  32'(in_use_count), 0);
   endtask

   task automatic do_reset();
      alloc_req = 0; free_req = 0; upd_valid = 0;
      reset = 1'b0;
      #1;
      check_zero("reset");
      @(negedge clock);
      model_clear();
      reset = 1'b1;
   endtask

   // called right after a negedge; drives one cycle and checks the registered response
   task automatic step(input bit a, input bit f, input int fa, input bit u,
                       input int ua, input int ui, input int qa);
      int  gh;
      bit  f_ok, u_ok;
      bit  e_ack, e_aerr, e_ferr, e_uerr;
      int  e_arr, e_qry, cnt;
      alloc_req = a; free_req = f; free_array = handle_t'(fa);
      upd_valid = u; upd_array = handle_t'(ua); upd_index = handle_t'(ui);
      qry_array = handle_t'(qa);
      gh = -1; e_ack = 0; e_arr = 0; e_aerr = 0; e_cause = ERR_NONE;
      if (a) begin
         if (fq.size() > 0) gh = fq.pop_back();
         else if (m_allocs < NA) begin gh = m_allocs; m_allocs++; end
         else begin e_aerr = 1; e_cause = ERR_NO_HANDLE; end
      end
      f_ok   = f && fa < NA && m_inuse[fa];
      e_ferr = f && !f_ok;
      u_ok   = u && ua < NA && ui < NAREA && m_inuse[ua];
      e_uerr = u && !u_ok;
      e_qry  = (qa < NA) ? m_size[qa] : 0;
      if (u_ok && ui + 1 > m_size[ua]) m_size[ua] = ui + 1;
      if (gh >= 0) begin
         m_size[gh] = 0; m_inuse[gh] = 1'b1; e_ack = 1; e_arr = gh;
      end
      if (f_ok) begin fq.push_back(fa); m_inuse[fa] = 1'b0; end
      cnt = 0;
      for (int i = 0; i < NA; i++) cnt += int'(m_inuse[i]);
      @(negedge clock);
      chk("alloc_ack",   32'(alloc_ack), 32'(e_ack));
      chk("alloc_array", 32'(alloc_array), 32'(e_arr));
      chk($sformatf("alloc_error_%s", e_cause.name()), 32'(alloc_error), 32'(e_aerr));
      chk("free_error",  32'(free_error), 32'(e_ferr));
      chk("upd_error",   32'(upd_error), 32'(e_uerr));
      chk("qry_size",    32'(qry_size), 32'(e_qry));
      chk("alloc_count", 32'(alloc_count), 32'(m_allocs));
      chk("in_use_count", 32'(in_use_count), 32'(cnt));
   endtask

   initial begin
      model_clear();
      #1;
      check_zero("por");
      @(negedge clock);
      reset = 1'b1;

      // four mints then exhaustion
      for (int i = 0; i < 4; i++) begin
         step(1, 0, 0, 0, 0, 0, 0);
         chk("mint_h", 32'(alloc_array), 32'(i));
      end
      chk("mint_cnt", 32'(alloc_count), 4);
      step(1, 0, 0, 0, 0, 0, 0);
      chk("exhaust_err", 32'(alloc_error), 1);

      // LIFO reuse
      do_reset();
      for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0, 0);
      step(0, 1, 1, 0, 0, 0, 0);
      step(0, 1, 2, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0);
      chk("lifo_first", 32'(alloc_array), 2);
      step(1, 0, 0, 0, 0, 0, 0);
      chk("lifo_second", 32'(alloc_array), 1);
      chk("lifo_cnt", 32'(alloc_count), 3);

      // size tracking on handle 0
      do_reset();
      step(1, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 1, 0, 2, 0);
      step(0, 0, 0, 1, 0, 3, 0);
      chk("size_after_idx2", 32'(qry_size), 3);
      step(0, 0, 0, 1, 0, 1, 0);
      chk("size_after_idx3", 32'(qry_size), 4);
      step(0, 0, 0, 1, 0, 8, 0);
      chk("upd_range_err", 32'(upd_error), 1);
      step(0, 0, 0, 0, 0, 0, 0);
      chk("size_kept", 32'(qry_size), 4);

      // double free and out-of-range free
      step(1, 0, 0, 0, 0, 0, 0);
      step(0, 1, 1, 0, 0, 0, 0);
      step(0, 1, 1, 0, 0, 0, 0);
      chk("double_free", 32'(free_error), 1);
      step(0, 1, 7, 0, 0, 0, 0);
      chk("range_free", 32'(free_error), 1);
      chk("range_free_cnt", 32'(in_use_count), 1);

      // simultaneous alloc and free with a non-empty stack
      do_reset();
      for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0, 0, 0);
      step(0, 1, 3, 1, 0, 5, 0);
      step(1, 1, 0, 0, 0, 0, 0);
      chk("swap_grant", 32'(alloc_array), 3);
      step(1, 0, 0, 0, 0, 0, 0);
      chk("swap_next", 32'(alloc_array), 0);
      step(0, 0, 0, 0, 0, 0, 0);
      chk("swap_size", 32'(qry_size), 0);

      // reset while a request is in flight
      alloc_req = 1'b1;
      #2 reset = 1'b0;
      #1;
      check_zero("midrst");
      @(negedge clock);
      chk("midrst_hold", 32'(alloc_ack), 0);
      model_clear();
      alloc_req = 1'b0;
      reset = 1'b1;
      step(1, 0, 0, 0, 0, 0, 0);
      chk("midrst_first", 32'(alloc_array), 0);

      // randomized traffic
      for (int n = 0; n < 600; n++) begin
         step(($urandom_range(0, 99) < 45), ($urandom_range(0, 99) < 40),
              int'($urandom_range(0, 7)), ($urandom_range(0, 99) < 60),
              int'($urandom_range(0, 5)), int'($urandom_range(0, 9)),
              int'($urandom_range(0, 5)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
